// File: rtl/game_pkg.sv
// Shared types and widths for the paddle-game frame sequencer.
package game_pkg;

    // Top-level game phases.
    typedef enum logic [1:0] {
        ATTRACT = 2'd0,
        SERVE   = 2'd1,
        PLAY    = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam int SPEED_W = 3;
    localparam int LIVES_W = 3;

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the frame sequencer and the rest of the game:
// frame/button/collision inputs in, update strobes and score state out.
interface game_seq_if
    import game_pkg::*;
#(
    parameter int SCORE_W = 8
);
    logic               frame_tick;
    logic               btn_up;
    logic               btn_down;
    logic               paddle_hit;
    logic               ball_miss;
    logic               paddle_step;
    logic               ball_step;
    logic               ball_center;
    logic               game_over;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [SPEED_W-1:0] speed;

    // Side that drives frame timing, buttons and collision pulses.
    modport master (
        output frame_tick, btn_up, btn_down, paddle_hit, ball_miss,
        input  paddle_step, ball_step, ball_center, game_over, lives, score, speed
    );

    // The sequencer itself.
    modport slave (
        input  frame_tick, btn_up, btn_down, paddle_hit, ball_miss,
        output paddle_step, ball_step, ball_center, game_over, lives, score, speed
    );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level. The edge is only
// reported once a real sample has been taken after reset, so a button held
// down through reset never looks like a fresh press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic prev_q;
    logic primed_q;

    // Keep last cycle's level and note that the history is now valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= din;
            primed_q <= 1'b1;
        end
    end

    assign rise = primed_q & din & ~prev_q;
endmodule

// File: rtl/game_sequencer.sv
// Frame-level controller for the paddle game: ATTRACT/SERVE/PLAY/OVER
// sequencing, per-frame update strobes, lives, score and ball speed.
// Optional feature macro: GAME_SEQ_SPEEDUP_EN -- when defined, every
// HITS_PER_LEVEL paddle hits raise the ball speed up to MAX_SPEED; when
// undefined the hit counter is absent and speed stays at 1.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int SCORE_W        = 8,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_SPEED      = 4
) (
    input  logic       clk,
    input  logic       reset,
    game_seq_if.slave  bus
);
    localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    game_state_t        state_q;
    game_state_t        state_d;
    logic [SERVE_W-1:0] serve_cnt_q;
    logic [LIVES_W-1:0] lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               paddle_step_q;
    logic               ball_step_q;

    logic up_rise;
    logic down_rise;
    logic press;
    logic new_game;
    logic serve_done;
    logic hit_ok;
    logic miss_ok;
    logic last_life;

    btn_edge u_up_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_up),
        .rise  (up_rise)
    );

    btn_edge u_down_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_down),
        .rise  (down_rise)
    );

    // Qualify raw inputs with the current phase; a miss always beats a hit.
    always_comb begin
        press      = up_rise | down_rise;
        new_game   = press & ((state_q == ATTRACT) | (state_q == OVER));
        serve_done = (state_q == SERVE) & bus.frame_tick & (serve_cnt_q == SERVE_LAST);
        miss_ok    = (state_q == PLAY) & bus.ball_miss;
        hit_ok     = (state_q == PLAY) & bus.paddle_hit & ~bus.ball_miss;
        last_life  = (lives_q == LIVES_W'(1));
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ATTRACT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase and the phase-derived level outputs.
    always_comb begin
        state_d         = state_q;
        bus.ball_center = 1'b0;
        bus.game_over   = 1'b0;
        case (state_q)
            ATTRACT: begin
                bus.ball_center = 1'b1;
                if (new_game) state_d = SERVE;
            end
            SERVE: begin
                bus.ball_center = 1'b1;
                if (serve_done) state_d = PLAY;
            end
            PLAY: begin
                if (miss_ok) state_d = last_life ? OVER : SERVE;
            end
            OVER: begin
                bus.game_over = 1'b1;
                if (new_game) state_d = SERVE;
            end
            default: state_d = ATTRACT;
        endcase
    end

    // Serve hold counter: frames spent centered, zero whenever not serving.
    always_ff @(posedge clk) begin
        if (reset || (state_q != SERVE)) begin
            serve_cnt_q <= '0;
        end else if (bus.frame_tick) begin
            serve_cnt_q <= serve_done ? '0 : serve_cnt_q + 1'b1;
        end
    end

    // Lives and score bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            lives_q <= LIVES_INIT;
            score_q <= '0;
        end else if (miss_ok) begin
            lives_q <= lives_q - 1'b1;
        end else if (hit_ok && (score_q != {SCORE_W{1'b1}})) begin
            score_q <= score_q + 1'b1;
        end
    end

    // Per-frame update strobes: paddle moves while serving or playing,
    // the ball only moves while playing.
    always_ff @(posedge clk) begin
        if (reset) begin
            paddle_step_q <= 1'b0;
            ball_step_q   <= 1'b0;
        end else begin
            paddle_step_q <= bus.frame_tick & ((state_q == SERVE) | (state_q == PLAY));
            ball_step_q   <= bus.frame_tick & (state_q == PLAY);
        end
    end

`ifdef GAME_SEQ_SPEEDUP_EN
    localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);

    logic [HIT_W-1:0]   hit_cnt_q;
    logic [SPEED_W-1:0] speed_q;

    // Count hits toward the next level; speed survives misses, not new games.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            hit_cnt_q <= '0;
            speed_q   <= SPEED_W'(1);
        end else if (hit_ok) begin
            if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_q <= '0;
                if (speed_q < SPEED_MAX) speed_q <= speed_q + 1'b1;
            end else begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
        end
    end

    assign bus.speed = speed_q;
`else
    assign bus.speed = SPEED_W'(1);
`endif

    assign bus.paddle_step = paddle_step_q;
    assign bus.ball_step   = ball_step_q;
    assign bus.lives       = lives_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a directed vector table covering the game flow,
// hand-written corner sequences, then random traffic against a reference model.
module tb_game_sequencer;
    localparam int LIVES          = 2;
    localparam int SERVE_FRAMES   = 2;
    localparam int SCORE_W        = 8;
    localparam int HITS_PER_LEVEL = 2;
    localparam int MAX_SPEED      = 4;
    localparam int SCORE_MAX      = (1 << SCORE_W) - 1;
`ifdef GAME_SEQ_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_seq_if #(.SCORE_W(SCORE_W)) bus ();

    game_sequencer #(
        .LIVES          (LIVES),
        .SERVE_FRAMES   (SERVE_FRAMES),
        .SCORE_W        (SCORE_W),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .MAX_SPEED      (MAX_SPEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    typedef enum int {MS_ATTRACT, MS_SERVE, MS_PLAY, MS_OVER} mode_t;
    mode_t m_mode;
    bit    m_ps, m_bs;
    int    m_lives, m_score, m_speed, m_frames, m_hits;
    bit    m_prev_up, m_prev_dn, m_hist_ok;

    function automatic void model_new_game();
        m_lives  = LIVES;
        m_score  = 0;
        m_speed  = 1;
        m_hits   = 0;
        m_frames = 0;
    endfunction

    // One clock edge worth of game rules, given the inputs seen at that edge.
    function automatic void model_step(bit r, bit up, bit dn, bit tick, bit hit, bit miss);
        bit press;
        if (r) begin
            m_mode = MS_ATTRACT;
            m_ps = 0; m_bs = 0;
            model_new_game();
            m_prev_up = 0; m_prev_dn = 0; m_hist_ok = 0;
            return;
        end
        press = m_hist_ok && ((up && !m_prev_up) || (dn && !m_prev_dn));
        m_prev_up = up; m_prev_dn = dn; m_hist_ok = 1;
        m_ps = tick && (m_mode == MS_SERVE || m_mode == MS_PLAY);
        m_bs = tick && (m_mode == MS_PLAY);
        case (m_mode)
            MS_ATTRACT, MS_OVER: begin
                if (press) begin
                    model_new_game();
                    m_mode = MS_SERVE;
                end
            end
            MS_SERVE: begin
                if (tick) begin
                    m_frames++;
                    if (m_frames == SERVE_FRAMES) begin
                        m_frames = 0;
                        m_mode = MS_PLAY;
                    end
                end
            end
            MS_PLAY: begin
                if (miss) begin
                    m_lives--;
                    m_mode = (m_lives == 0) ? MS_OVER : MS_SERVE;
                    m_frames = 0;
                end else if (hit) begin
                    if (m_score < SCORE_MAX) m_score++;
                    if (SPEEDUP) begin
                        m_hits++;
                        if (m_hits == HITS_PER_LEVEL) begin
                            m_hits = 0;
                            if (m_speed < MAX_SPEED) m_speed++;
                        end
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [17:0] pack(bit ps, bit bs, bit bc, bit go, int lv, int sc, int sp);
        return {ps, bs, bc, go, 3'(lv), 8'(sc), 3'(sp)};
    endfunction

    function automatic logic [17:0] model_exp();
        return pack(m_ps, m_bs, (m_mode == MS_ATTRACT) || (m_mode == MS_SERVE),
                    m_mode == MS_OVER, m_lives, m_score, m_speed);
    endfunction

    function automatic int sp(int n);
        return SPEEDUP ? n : 1;
    endfunction

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = {bus.paddle_step, bus.ball_step, bus.ball_center, bus.game_over,
               bus.lives, bus.score, bus.speed};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got ps=%0b bs=%0b bc=%0b go=%0b lives=%0d score=%0d speed=%0d ; want ps=%0b bs=%0b bc=%0b go=%0b lives=%0d score=%0d speed=%0d",
                     name, got[17], got[16], got[15], got[14], got[13:11], got[10:3], got[2:0],
                     exp[17], exp[16], exp[15], exp[14], exp[13:11], exp[10:3], exp[2:0]);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input bit r, input bit u, input bit d, input bit t, input bit h, input bit m);
        @(negedge clk);
        reset          = r;
        bus.btn_up     = u;
        bus.btn_down   = d;
        bus.frame_tick = t;
        bus.paddle_hit = h;
        bus.ball_miss  = m;
        model_step(r, u, d, t, h, m);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst, up, dn, tick, hit, miss;
        bit ps, bs, bc, go;
        int lives, score, speed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit u, bit d, bit t, bit h, bit m,
                                bit ps, bit bs, bit bc, bit go, int lv, int sc, int spd);
        vec_t v;
        v.rst = r; v.up = u; v.dn = d; v.tick = t; v.hit = h; v.miss = m;
        v.ps = ps; v.bs = bs; v.bc = bc; v.go = go;
        v.lives = lv; v.score = sc; v.speed = spd;
        vecs.push_back(v);
    endfunction

    initial begin
        bit u, d, t, h, m, r;

        reset = 1'b1;
        bus.btn_up = 0; bus.btn_down = 0; bus.frame_tick = 0;
        bus.paddle_hit = 0; bus.ball_miss = 0;

        //   rst up dn tk ht ms   ps bs bc go lives score speed
        add(1, 0, 0, 0, 0, 0,    0, 0, 1, 0, 2, 0, 1);       // reset
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 1);      // ticks in ATTRACT
        add(0, 1, 0, 0, 0, 0,    0, 0, 1, 0, 2, 0, 1);       // press -> SERVE
        add(0, 1, 0, 1, 0, 0,    1, 0, 1, 0, 2, 0, 1);       // serve tick 1
        add(0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 2, 0, 1);
        add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 2, 0, 1);       // serve tick 2 -> PLAY
        add(0, 0, 0, 1, 0, 0,    1, 1, 0, 0, 2, 0, 1);       // both strobes
        add(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1,    0, 0, 1, 0, 1, 0, 1);       // miss -> SERVE
        add(0, 0, 0, 1, 0, 0,    1, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 1, 0, 1);       // -> PLAY
        add(0, 0, 0, 0, 0, 1,    0, 0, 0, 1, 0, 0, 1);       // last miss -> OVER
        add(0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 0, 0, 1);       // no strobe in OVER
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 1, 0, 0, 1);       // hit ignored in OVER
        add(0, 0, 1, 0, 0, 0,    0, 0, 1, 0, 2, 0, 1);       // down press -> SERVE
        add(0, 0, 0, 1, 0, 0,    1, 0, 1, 0, 2, 0, 1);
        add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 2, 0, 1);       // -> PLAY
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 2, 1, sp(1));
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 2, 2, sp(2));
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 2, 3, sp(2));
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 2, 4, sp(3));
        add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 2, 5, sp(3));
        add(0, 0, 0, 0, 1, 1,    0, 0, 1, 0, 1, 5, sp(3));   // hit+miss: miss wins
        add(0, 0, 0, 1, 0, 0,    1, 0, 1, 0, 1, 5, sp(3));
        add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 1, 5, sp(3));   // -> PLAY
        add(1, 0, 0, 1, 1, 0,    0, 0, 1, 0, 2, 0, 1);       // reset mid-PLAY
        add(0, 0, 0, 1, 0, 0,    0, 0, 1, 0, 2, 0, 1);       // back in ATTRACT

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].tick, vecs[i].hit, vecs[i].miss);
            check($sformatf("vec%0d", i),
                  pack(vecs[i].ps, vecs[i].bs, vecs[i].bc, vecs[i].go,
                       vecs[i].lives, vecs[i].score, vecs[i].speed));
        end

        // Button held through reset must not start a game.
        step(1, 1, 0, 0, 0, 0);
        check("held_reset", pack(0, 0, 1, 0, 2, 0, 1));
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        check("held_no_press", pack(0, 0, 1, 0, 2, 0, 1));
        step(0, 0, 0, 0, 0, 0);
        // Press coincident with a tick in ATTRACT: transition, no strobe.
        step(0, 1, 0, 1, 0, 0);
        check("press_tick", pack(0, 0, 1, 0, 2, 0, 1));
        step(0, 0, 0, 1, 0, 0);
        check("serve_after_press_tick", pack(1, 0, 1, 0, 2, 0, 1));
        step(0, 0, 0, 1, 0, 0);
        check("play_after_press_tick", pack(1, 0, 0, 0, 2, 0, 1));

        // Score saturation and speed ceiling.
        for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 1, 0);
        check("score_saturate", pack(0, 0, 0, 0, 2, SCORE_MAX, sp(MAX_SPEED)));

        // Random traffic against the model.
        u = 0; d = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 9) == 0) d = ~d;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 24) == 0);
            step(r, u, d, t, h, m);
            check($sformatf("rand%0d", i), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
